mac_operand_feeder: RTL

Upstream sequencer for the 16x16 MAC. It buffers incoming operand pairs in a small FIFO and drives A/B plus the MAC's clear line, so that the MAC computes exactly one dot product of a programmed length per start command. The MAC has no enable, so the feeder inserts zero-valued bubbles whenever it has no data. It then holds the result stable until downstream acknowledges it.

---
 rtl/mac_operand_feeder_if.sv | 32 +++
 rtl/mac_operand_feeder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder_if.sv
// Handshake bundle between the MAC operand feeder and its neighbours.
// Upstream operands/commands in; MAC drive and result status out.
interface mac_operand_feeder_if #(
  parameter int DW   = 16,
  parameter int LENW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic            start;
  logic [LENW-1:0] vec_len;
  logic [DW-1:0]   a_out;
  logic [DW-1:0]   b_out;
  logic            mac_clr;
  logic            busy;
  logic            res_valid;
  logic            res_ack;
  logic [15:0]     bubble_cnt;

  modport master (
    output in_valid, in_a, in_b, start, vec_len, res_ack,
    input  in_ready, a_out, b_out, mac_clr, busy, res_valid,
    input  bubble_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b, start, vec_len, res_ack,
    output in_ready, a_out, b_out, mac_clr, busy, res_valid,
    output bubble_cnt
  );
endinterface

// File: rtl/mac_operand_feeder.sv
// Operand FIFO + dot-product sequencer feeding the 16x16 MAC.
// Define MAC_FEED_STATS_EN to build the bubble_cnt statistics counter.
module mac_operand_feeder #(
  parameter int DW      = 16,
  parameter int DEPTH   = 8,
  parameter int LENW    = 8,
  parameter int MAC_LAT = 1
) (
  input logic clk,
  input logic reset,
  mac_operand_feeder_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int DCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE, CLEAR, RUN, DRAIN, HOLD
  } state_t;

  state_t state, state_n;

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     fcnt;
  logic            full, empty, push, pop;

  logic [LENW-1:0] len_r, cnt;
  logic [DCW-1:0]  dcnt;
  logic            go, ack, last_pop, drain_done;

  logic [DW-1:0]   a_d, b_d;
  logic            clr_d, rv_d;

  assign full       = (fcnt == (AW+1)'(DEPTH));
  assign empty      = (fcnt == '0);
  assign push       = bus.in_valid && !full;
  assign pop        = (state == RUN) && !empty;
  assign go         = (state == IDLE) && bus.start;
  assign ack        = (state == HOLD) && bus.res_valid && bus.res_ack;
  assign last_pop   = pop && ((cnt + LENW'(1)) == len_r);
  assign drain_done = (dcnt == DCW'(MAC_LAT - 1));

  assign bus.in_ready = !full;
  assign bus.busy     = (state != IDLE);

  // Operand storage; validity is tracked by fcnt so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {bus.in_a, bus.in_b};
  end

  // FIFO pointers and occupancy, wrapping modulo DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fcnt <= fcnt + (AW+1)'(1);
        2'b01:   fcnt <= fcnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Sequencer next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (go) state_n = CLEAR;
      CLEAR:   state_n = (len_r != '0) ? RUN : DRAIN;
      RUN:     if (last_pop) state_n = DRAIN;
      DRAIN:   if (drain_done) state_n = HOLD;
      HOLD:    if (ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered MAC drive and result flag
  always_comb begin
    a_d   = '0;
    b_d   = '0;
    clr_d = 1'b0;
    rv_d  = 1'b0;
    unique case (state)
      IDLE, CLEAR: clr_d = 1'b1;
      RUN:         if (pop) {a_d, b_d} = mem[rptr];
      HOLD: begin
        clr_d = ack;
        rv_d  = !ack;
      end
      default: ;
    endcase
  end

  // MAC drive registers; bubbles are zero so the MAC adds nothing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.a_out     <= '0;
      bus.b_out     <= '0;
      bus.mac_clr   <= 1'b1;
      bus.res_valid <= 1'b0;
    end else begin
      bus.a_out     <= a_d;
      bus.b_out     <= b_d;
      bus.mac_clr   <= clr_d;
      bus.res_valid <= rv_d;
    end
  end

  // Vector length latch, pair count and drain timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r <= '0;
      cnt   <= '0;
      dcnt  <= '0;
    end else begin
      if (go) begin
        len_r <= bus.vec_len;
        cnt   <= '0;
      end else if (pop) begin
        cnt <= cnt + LENW'(1);
      end
      dcnt <= (state == DRAIN) ? dcnt + DCW'(1) : '0;
    end
  end

`ifdef MAC_FEED_STATS_EN
  logic [15:0] bub;

  // Saturating count of empty-FIFO RUN cycles, cleared by start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bub <= '0;
    end else if (go) begin
      bub <= '0;
    end else if (pop == 1'b0 && state == RUN && bub != 16'hFFFF) begin
      bub <= bub + 16'd1;
    end
  end

  assign bus.bubble_cnt = bub;
`else
  assign bus.bubble_cnt = '0;
`endif
endmodule
